// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, load/store and memory command signals of the port arbiter
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    // Fetch requester
    logic                  i_Fetch_Req;
    logic [ADDR_WIDTH-1:0] i_Fetch_Addr;
    logic                  o_Fetch_Grant;
    logic                  o_Fetch_Valid;
    logic [DATA_WIDTH-1:0] o_Fetch_Data;

    // Load/store requester
    logic                  i_Data_Req;
    logic                  i_Data_Write_Enable;
    logic [ADDR_WIDTH-1:0] i_Data_Addr;
    logic [DATA_WIDTH-1:0] i_Data_Write_Data;
    logic                  o_Data_Grant;
    logic                  o_Data_Valid;
    logic [DATA_WIDTH-1:0] o_Data_Read_Data;

    // Unified memory
    logic                  o_Mem_Read_Enable;
    logic                  o_Mem_Write_Enable;
    logic [ADDR_WIDTH-1:0] o_Mem_Addr;
    logic [DATA_WIDTH-1:0] o_Mem_Write_Data;
    logic [DATA_WIDTH-1:0] i_Mem_Read_Data;

    // Control unit stall
    logic                  o_Busy;

    // Requesters and memory side
    modport master (
        output i_Fetch_Req, i_Fetch_Addr,
        input  o_Fetch_Grant, o_Fetch_Valid, o_Fetch_Data,
        output i_Data_Req, i_Data_Write_Enable, i_Data_Addr, i_Data_Write_Data,
        input  o_Data_Grant, o_Data_Valid, o_Data_Read_Data,
        input  o_Mem_Read_Enable, o_Mem_Write_Enable, o_Mem_Addr, o_Mem_Write_Data,
        output i_Mem_Read_Data,
        input  o_Busy
    );

    // Arbiter side
    modport slave (
        input  i_Fetch_Req, i_Fetch_Addr,
        output o_Fetch_Grant, o_Fetch_Valid, o_Fetch_Data,
        input  i_Data_Req, i_Data_Write_Enable, i_Data_Addr, i_Data_Write_Data,
        output o_Data_Grant, o_Data_Valid, o_Data_Read_Data,
        output o_Mem_Read_Enable, o_Mem_Write_Enable, o_Mem_Addr, o_Mem_Write_Data,
        input  i_Mem_Read_Data,
        output o_Busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch vs load/store arbiter for one fixed-latency memory port (optional ARB_STARVE_GUARD_EN)
module mem_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [3:0] LAT_INIT    = 4'(MEM_LATENCY);
    localparam logic       OWNER_FETCH = 1'b0;
    localparam logic       OWNER_DATA  = 1'b1;

    state_t                state_q;
    state_t                state_d;

    logic                  owner_q;
    logic                  we_q;
    logic [3:0]            cnt_q;

    logic                  mem_re_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;

    logic                  grant_fetch;
    logic                  grant_data;
    logic                  any_grant;
    logic                  wait_last;
    logic                  fetch_first;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0]            starve_q;

    // Once fetch has lost STARVE_LIMIT arbitrations in a row it takes the next one
    assign fetch_first = bus.i_Fetch_Req && (starve_q == STARVE_MAX);

    // Count consecutive data wins that left a fetch waiting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_q <= 4'd0;
        end else if (grant_fetch) begin
            starve_q <= 4'd0;
        end else if (grant_data) begin
            if (!bus.i_Fetch_Req) begin
                starve_q <= 4'd0;
            end else if (starve_q != STARVE_MAX) begin
                starve_q <= starve_q + 4'd1;
            end
        end
    end
`else
    // Strict priority: the load/store belongs to the older instruction
    assign fetch_first = 1'b0;
`endif

    assign any_grant = grant_fetch | grant_data;
    assign wait_last = (state_q == S_WAIT) && (cnt_q == 4'd1);

    // Next-state and arbitration; grants are held off while reset is asserted
    always_comb begin
        state_d     = state_q;
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (reset) begin
                    if (bus.i_Data_Req && !fetch_first) begin
                        grant_data = 1'b1;
                    end else if (bus.i_Fetch_Req) begin
                        grant_fetch = 1'b1;
                    end
                end
                if (grant_data || grant_fetch) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any access in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Owner, direction and latency counter for the access in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q <= OWNER_FETCH;
            we_q    <= 1'b0;
            cnt_q   <= 4'd0;
        end else if (any_grant) begin
            owner_q <= grant_data ? OWNER_DATA : OWNER_FETCH;
            we_q    <= grant_data && bus.i_Data_Write_Enable;
            cnt_q   <= LAT_INIT;
        end else if (state_q == S_WAIT) begin
            cnt_q   <= (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
        end
    end

    // Memory command: captured at grant, presented only during ISSUE, zero otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else if (grant_data) begin
            mem_re_q    <= !bus.i_Data_Write_Enable;
            mem_we_q    <= bus.i_Data_Write_Enable;
            mem_addr_q  <= bus.i_Data_Addr;
            mem_wdata_q <= bus.i_Data_Write_Enable ? bus.i_Data_Write_Data : '0;
        end else if (grant_fetch) begin
            mem_re_q    <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.i_Fetch_Addr;
            mem_wdata_q <= '0;
        end else begin
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end
    end

    assign bus.o_Fetch_Grant      = grant_fetch;
    assign bus.o_Data_Grant       = grant_data;

    assign bus.o_Fetch_Valid      = wait_last && (owner_q == OWNER_FETCH);
    assign bus.o_Data_Valid       = wait_last && (owner_q == OWNER_DATA);

    // Read data is passed straight through to the owner only in its valid cycle
    assign bus.o_Fetch_Data       = (wait_last && (owner_q == OWNER_FETCH))
                                    ? bus.i_Mem_Read_Data : '0;
    assign bus.o_Data_Read_Data   = (wait_last && (owner_q == OWNER_DATA) && !we_q)
                                    ? bus.i_Mem_Read_Data : '0;

    assign bus.o_Mem_Read_Enable  = mem_re_q;
    assign bus.o_Mem_Write_Enable = mem_we_q;
    assign bus.o_Mem_Addr         = mem_addr_q;
    assign bus.o_Mem_Write_Data   = mem_wdata_q;

    assign bus.o_Busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int L = 2;
    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    localparam int K_FGRANT = 0;
    localparam int K_DGRANT = 1;
    localparam int K_MEMRD  = 2;
    localparam int K_MEMWR  = 3;
    localparam int K_FVALID = 4;
    localparam int K_DVALID = 5;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
        bit          chk_data;
    } ev_t;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    ev_t  exp_q[$];

    mem_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    mem_port_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(L), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h100) return 32'hE3A0_1005;
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    task automatic push(input int kind, input int c, input logic [31:0] a,
                        input logic [31:0] d, input bit cd);
        ev_t e;
        e.kind = kind; e.cyc = c; e.addr = a; e.data = d; e.chk_data = cd;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got kind=%0d cyc=%0d addr=%h data=%h, required no event",
                     kind, cyc, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.addr != a || (e.chk_data && e.data != d)) begin
                failures++;
                $display("FAIL event_mismatch: got kind=%0d cyc=%0d addr=%h data=%h, required kind=%0d cyc=%0d addr=%h data=%h",
                         kind, cyc, a, d, e.kind, e.cyc, e.addr, e.data);
            end
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic check_all_zero(input string name);
        logic [134:0] v;
        v = {bus.o_Fetch_Grant, bus.o_Data_Grant, bus.o_Fetch_Valid, bus.o_Data_Valid,
             bus.o_Fetch_Data, bus.o_Data_Read_Data, bus.o_Mem_Read_Enable,
             bus.o_Mem_Write_Enable, bus.o_Mem_Addr, bus.o_Mem_Write_Data, bus.o_Busy};
        checks++;
        if (v !== '0) begin
            failures++;
            $display("FAIL %s: outputs=%h, required all zero", name, v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    // Monitor: pops the scoreboard for every event the DUT presents
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                if (bus.o_Fetch_Grant)      observe(K_FGRANT, 32'h0, 32'h0);
                if (bus.o_Data_Grant)       observe(K_DGRANT, 32'h0, 32'h0);
                if (bus.o_Mem_Read_Enable)  observe(K_MEMRD, bus.o_Mem_Addr, 32'h0);
                if (bus.o_Mem_Write_Enable) observe(K_MEMWR, bus.o_Mem_Addr, bus.o_Mem_Write_Data);
                if (bus.o_Fetch_Valid)      observe(K_FVALID, 32'h0, bus.o_Fetch_Data);
                if (bus.o_Data_Valid)       observe(K_DVALID, 32'h0, bus.o_Data_Read_Data);
                checks++;
                if ((bus.o_Fetch_Grant && bus.o_Data_Grant) || (bus.o_Fetch_Valid && bus.o_Data_Valid)) begin
                    failures++;
                    $display("FAIL exclusive: cyc=%0d grants=%b%b valids=%b%b, required at most one",
                             cyc, bus.o_Fetch_Grant, bus.o_Data_Grant, bus.o_Fetch_Valid, bus.o_Data_Valid);
                end
                checks++;
                if ((!bus.o_Fetch_Valid && bus.o_Fetch_Data != 0) ||
                    (!bus.o_Data_Valid && bus.o_Data_Read_Data != 0) ||
                    (!bus.o_Mem_Read_Enable && !bus.o_Mem_Write_Enable &&
                     (bus.o_Mem_Addr != 0 || bus.o_Mem_Write_Data != 0))) begin
                    failures++;
                    $display("FAIL idle_bus_zero: cyc=%0d fdata=%h ddata=%h maddr=%h mwdata=%h, required 0",
                             cyc, bus.o_Fetch_Data, bus.o_Data_Read_Data, bus.o_Mem_Addr, bus.o_Mem_Write_Data);
                end
            end
        end
    end

    // Fixed-latency memory: read data appears L cycles after the read command
    initial begin
        logic [31:0] pipe [L];
        logic        re_s;
        logic [31:0] a_s;
        for (int i = 0; i < L; i++) pipe[i] = JUNK;
        bus.i_Mem_Read_Data = JUNK;
        forever begin
            @(negedge clk);
            re_s = bus.o_Mem_Read_Enable;
            a_s  = bus.o_Mem_Addr;
            @(posedge clk);
            #1;
            for (int i = L - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = re_s ? mem_val(a_s) : JUNK;
            bus.i_Mem_Read_Data = pipe[L-1];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Directed stimulus
    initial begin
        int c;
        bit fwin;
        reset = 1'b0;
        bus.i_Fetch_Req = 1'b0;
        bus.i_Fetch_Addr = '0;
        bus.i_Data_Req = 1'b1;
        bus.i_Data_Write_Enable = 1'b0;
        bus.i_Data_Addr = 32'h44;
        bus.i_Data_Write_Data = '0;

        tick();
        tick();
        check_all_zero("reset_state");
        bus.i_Data_Req = 1'b0;
        reset = 1'b1;
        tick();

        // Single fetch
        c = cyc;
        bus.i_Fetch_Req = 1'b1;
        bus.i_Fetch_Addr = 32'h100;
        push(K_FGRANT, c, 0, 0, 0);
        push(K_MEMRD, c + 1, 32'h100, 0, 0);
        push(K_FVALID, c + 3, 0, 32'hE3A0_1005, 1);
        tick();
        bus.i_Fetch_Req = 1'b0;
        check_bit("busy_t1", bus.o_Busy, 1'b1);
        wait_until(c + 3);
        check_bit("busy_t3", bus.o_Busy, 1'b1);
        wait_until(c + 4);
        check_bit("busy_t4", bus.o_Busy, 1'b0);

        // Store
        tick();
        c = cyc;
        bus.i_Data_Req = 1'b1;
        bus.i_Data_Write_Enable = 1'b1;
        bus.i_Data_Addr = 32'h200;
        bus.i_Data_Write_Data = 32'hDEAD_BEEF;
        push(K_DGRANT, c, 0, 0, 0);
        push(K_MEMWR, c + 1, 32'h200, 32'hDEAD_BEEF, 1);
        push(K_DVALID, c + 3, 0, 0, 0);
        tick();
        bus.i_Data_Req = 1'b0;
        bus.i_Data_Write_Enable = 1'b0;
        wait_until(c + 4);
        check_bit("busy_store_end", bus.o_Busy, 1'b0);

        // Fetch and load together: data first, fetch on IDLE re-entry
        tick();
        c = cyc;
        bus.i_Fetch_Req = 1'b1;
        bus.i_Fetch_Addr = 32'h300;
        bus.i_Data_Req = 1'b1;
        bus.i_Data_Addr = 32'h400;
        push(K_DGRANT, c, 0, 0, 0);
        push(K_MEMRD, c + 1, 32'h400, 0, 0);
        push(K_DVALID, c + 3, 0, mem_val(32'h400), 1);
        push(K_FGRANT, c + 4, 0, 0, 0);
        push(K_MEMRD, c + 5, 32'h300, 0, 0);
        push(K_FVALID, c + 7, 0, mem_val(32'h300), 1);
        tick();
        bus.i_Data_Req = 1'b0;
        wait_until(c + 5);
        bus.i_Fetch_Req = 1'b0;
        wait_until(c + 8);

        // Both requests held continuously
        tick();
        c = cyc;
        bus.i_Fetch_Req = 1'b1;
        bus.i_Fetch_Addr = 32'h600;
        bus.i_Data_Req = 1'b1;
        bus.i_Data_Addr = 32'h500;
        for (int k = 0; k < 10; k++) begin
`ifdef ARB_STARVE_GUARD_EN
            fwin = (k == 4) || (k == 9);
`else
            fwin = 1'b0;
`endif
            push(fwin ? K_FGRANT : K_DGRANT, c + 4 * k, 0, 0, 0);
            push(K_MEMRD, c + 4 * k + 1, fwin ? 32'h600 : 32'h500, 0, 0);
            push(fwin ? K_FVALID : K_DVALID, c + 4 * k + 3, 0,
                 mem_val(fwin ? 32'h600 : 32'h500), 1);
        end
        wait_until(c + 37);
        bus.i_Fetch_Req = 1'b0;
        bus.i_Data_Req = 1'b0;
        wait_until(c + 40);

        // Reset pulled in WAIT aborts the load; held request is granted on release
        tick();
        c = cyc;
        bus.i_Data_Req = 1'b1;
        bus.i_Data_Addr = 32'h700;
        push(K_DGRANT, c, 0, 0, 0);
        push(K_MEMRD, c + 1, 32'h700, 0, 0);
        wait_until(c + 2);
        reset = 1'b0;
        #1;
        check_all_zero("reset_in_wait");
        wait_until(c + 3);
        check_all_zero("reset_held");
        wait_until(c + 4);
        bus.i_Data_Addr = 32'h710;
        reset = 1'b1;
        push(K_DGRANT, c + 4, 0, 0, 0);
        push(K_MEMRD, c + 5, 32'h710, 0, 0);
        push(K_DVALID, c + 7, 0, mem_val(32'h710), 1);
        tick();
        bus.i_Data_Req = 1'b0;
        wait_until(c + 8);

        // Fetch request withdrawn before grant while a load is in flight
        tick();
        c = cyc;
        bus.i_Data_Req = 1'b1;
        bus.i_Data_Addr = 32'h800;
        push(K_DGRANT, c, 0, 0, 0);
        push(K_MEMRD, c + 1, 32'h800, 0, 0);
        push(K_DVALID, c + 3, 0, mem_val(32'h800), 1);
        tick();
        bus.i_Data_Req = 1'b0;
        bus.i_Fetch_Req = 1'b1;
        bus.i_Fetch_Addr = 32'h900;
        tick();
        bus.i_Fetch_Req = 1'b0;
        wait_until(c + 4);
        check_bit("busy_after_drop", bus.o_Busy, 1'b0);
        wait_until(c + 8);
        check_bit("busy_stays_idle", bus.o_Busy, 1'b0);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_events: got %0d unmatched expected events, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, fixed-latency memory between the instruction-fetch requester and the load/store (LDR/STR) requester of the ARMv7 core. Each requester gets a request/grant/valid handshake. The arbiter serialises accesses, drives the memory command and routes read data back to the winning requester. It sits between the fetch/datapath logic and the unified memory; the control unit stalls on `o_Busy`.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data width of requesters and memory.
- `ADDR_WIDTH`, 32, byte address width.
- `MEM_LATENCY`, 2, cycles from command to read data (legal range 1..15).
- `STARVE_LIMIT`, 4, consecutive data wins allowed while fetch waits (legal range 1..15; used only with the starvation guard).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `i_Fetch_Req`  in  1  fetch request, level.
- `i_Fetch_Addr`  in  ADDR_WIDTH  fetch address.
- `o_Fetch_Grant`  out  1  fetch request accepted this cycle.
- `o_Fetch_Valid`  out  1  `o_Fetch_Data` valid this cycle.
- `o_Fetch_Data`  out  DATA_WIDTH  instruction word.
- `i_Data_Req`  in  1  load/store request, level.
- `i_Data_Write_Enable`  in  1  1 = store, 0 = load.
- `i_Data_Addr`  in  ADDR_WIDTH  load/store address.
- `i_Data_Write_Data`  in  DATA_WIDTH  store data.
- `o_Data_Grant`  out  1  data request accepted this cycle.
- `o_Data_Valid`  out  1  load data valid, or store completed.
- `o_Data_Read_Data`  out  DATA_WIDTH  load data.
- `o_Mem_Read_Enable`  out  1  memory read command strobe.
- `o_Mem_Write_Enable`  out  1  memory write command strobe.
- `o_Mem_Addr`  out  ADDR_WIDTH  memory address.
- `o_Mem_Write_Data`  out  DATA_WIDTH  memory write data.
- `i_Mem_Read_Data`  in  DATA_WIDTH  read data, valid `MEM_LATENCY` cycles after the command.
- `o_Busy`  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any request is high, select a winner and pulse its grant combinationally in the same cycle.
  - Latch the winner's address, write data, write-enable and owner ID.
  - Load the latency counter with `MEM_LATENCY`, then go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - The registered `o_Mem_*` command is high for exactly one cycle: read strobe for fetch or load, write strobe for store.
  - Go to WAIT.
- WAIT:
  - The counter decrements each cycle.
  - In the cycle the counter reaches 1, pulse the owner's `*_Valid`. On a read, `*_Data`/`*_Read_Data` carries `i_Mem_Read_Data` (combinational pass-through).
  - Return to IDLE on the next edge.
- Priority: data beats fetch when both requests are high in IDLE, because the load/store belongs to the older instruction.
- Request rules:
  - A requester holds req, addr and data stable until its grant.
  - Deasserting req before grant is legal and has no side effects.
  - Req sampled while not in IDLE is ignored; there is no queueing.
- When no owner is selected, the `*_Data`, `*_Read_Data` and `o_Mem_*` buses are 0. Grant and valid pulses are never asserted for both requesters in the same cycle.
- Reset:
  - Reset asserted mid-operation aborts the access immediately: state becomes IDLE, counters clear, all outputs go to 0, and no valid is generated.
  - All outputs reset to 0.

## Timing
- Accept at cycle T (grant high), command at T+1, valid at T+1+`MEM_LATENCY`, IDLE at T+2+`MEM_LATENCY`.
- The next grant comes no earlier than T+2+`MEM_LATENCY`, giving a throughput of one access per `MEM_LATENCY`+2 cycles.
- `o_Busy` is high from T+1 through T+1+`MEM_LATENCY` inclusive.
- Stores use the same latency; `o_Data_Valid` acts as the write acknowledge.
- With `MEM_LATENCY` = 1, WAIT lasts one cycle and carries the valid.

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - A starvation counter increments on each data grant issued while `i_Fetch_Req` is high.
  - It clears on any fetch grant, and also clears on a data grant issued while `i_Fetch_Req` is low.
  - When the counter equals `STARVE_LIMIT`, the next IDLE arbitration grants fetch even if data requests.
  - The counter resets to 0.
- Not defined: strict data-over-fetch priority; the counter logic is absent.

## Test plan
- Single fetch, `MEM_LATENCY`=2, addr 0x100, memory returns 0xE3A01005:
  - `o_Fetch_Grant` at T.
  - `o_Mem_Read_Enable` with `o_Mem_Addr`=0x100 at T+1.
  - `o_Fetch_Valid` with data 0xE3A01005 at T+3.
  - `o_Busy` low at T+4.
- Store to 0x200 with data 0xDEADBEEF:
  - `o_Mem_Write_Enable`=1 with addr and data at T+1, `o_Mem_Read_Enable`=0.
  - `o_Data_Valid` at T+3; no fetch outputs assert.
- Fetch and load requested together in IDLE:
  - Data is granted first.
  - Fetch is granted at T+4 (the cycle IDLE is re-entered); its valid comes at T+7.
- Both requests held high continuously with the guard enabled, `STARVE_LIMIT`=4: grant sequence is D,D,D,D,F,D,D,D,D,F. With the guard disabled, fetch is never granted.
- Reset pulled low in WAIT (the cycle after ISSUE): all outputs are 0 immediately, no valid pulses, and the first request after release is granted in the first IDLE cycle.
- Fetch req dropped before grant while a load is in flight: no fetch grant or valid ever occurs, and the arbiter returns to IDLE with `o_Busy`=0.
